param_shift_rotate_reg: RTL and testbench
=========================================

Name: param_shift_rotate_reg

Overview:
- Parametrised successor to the team's 4-mode universal shift register. Adds generic WIDTH, rotate and arithmetic-shift modes, and multi-bit shifts executed one bit per cycle.
- Commands use a valid/ready handshake; a done pulse marks completion.
- Sits as the datapath register in serial/parallel conversion paths. It is driven by the class-based test environment through the interface.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of the shift-amount field; max amount 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- op  in  3  operation code (see Behaviour).
- amt  in  CNT_W  shift/rotate step count.
- I_par  in  WIDTH  parallel load data.
- MSB_in  in  1  serial fill bit for SHR.
- LSB_in  in  1  serial fill bit for SHL.
- A_par  out  WIDTH  register contents.
- out_bit  out  1  last bit shifted or rotated out.
- busy  out  1  multi-cycle shift in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock is used. Reset is asynchronous and active-high.
- Reset values: A_par=0, out_bit=0, done=0, busy=0, FSM=IDLE.
  - cmd_ready=1 whenever FSM=IDLE, including during reset.
  - Commands presented while reset is high are dropped.
- Accept rule: a command is accepted at the rising edge where cmd_valid && cmd_ready. cmd_ready = (FSM==IDLE), combinational from state.
- op codes:
  - 000 HOLD: no change.
  - 001 LOAD: A_par<=I_par.
  - 010 SHL: fill from LSB_in; bit out is A_par[WIDTH-1].
  - 011 SHR: fill from MSB_in; bit out is A_par[0].
  - 100 ROTL: fill with A_par[WIDTH-1], which is also the bit out.
  - 101 ROTR: fill with A_par[0], which is also the bit out.
  - 110 ASR: fill with A_par[WIDTH-1]; bit out is A_par[0]; MSB_in is ignored.
  - 111 CLEAR: A_par<=0.
- HOLD/LOAD/CLEAR: take effect at the accepting edge. amt is ignored and out_bit is unchanged.
- Shift/rotate ops (010-110):
  - Exactly amt single-bit steps, one per edge. The first step occurs at the accepting edge.
  - amt is not reduced modulo WIDTH; ROTR by 12 on WIDTH=8 equals ROTR by 4.
  - SHL/SHR by amt>=WIDTH yields all fill bits.
  - Fill bits MSB_in/LSB_in are sampled live at each step edge, not latched at acceptance.
  - op, amt and I_par are latched at acceptance; later input changes have no effect.
  - out_bit updates on every step to the bit just shifted out.
- FSM, IDLE/SHIFT:
  - IDLE, accepted shift with amt>=2: go to SHIFT, remaining=amt-1.
  - SHIFT: one step per edge, remaining decrements. On the step that makes remaining 0, return to IDLE.
  - busy=1 exactly while in SHIFT.
- Latency:
  - A shift of amt>=1 completes amt edges after acceptance, counting the accepting edge.
  - cmd_ready is low for amt-1 cycles.
  - Single-cycle ops complete at the accepting edge.
- done: registered, high for exactly one cycle following the edge on which an op completes.
  - amt=0 on a shift op is a no-op: A_par and out_bit are unchanged, done pulses, and there is no SHIFT state.
- Back-to-back: in IDLE, a new command may be accepted on the same edge that done is asserted after. Commands held valid while busy wait without loss until cmd_ready.
- Reset mid-SHIFT: aborts immediately to reset values; no done pulse.

Test Plan:
- LOAD I_par=0xA5 -> A_par=0xA5 after the accepting edge; done high 1 cycle; busy never high. Then CLEAR -> A_par=0x00.
- From 0xA5, SHL amt=3 with LSB_in=1 -> A_par steps 0x4B, 0x97, 0x2F; out_bit=1; cmd_ready low 2 cycles; done 1 cycle after the 3rd edge.
- From 0x81, ROTR amt=12 -> final A_par=0x18, out_bit=0, busy for 11 cycles. Then ASR amt=2 from 0x90 with MSB_in=0 -> A_par=0xE4.
- SHL amt=0 from 0x3C -> A_par stays 0x3C, done pulses. HOLD -> value unchanged. A second cmd_valid held during a busy shift is accepted only on the first edge with cmd_ready=1.
- SHR amt=5 from 0xFF, toggling MSB_in 1,0,1,0,1 per step -> A_par=0xAF. This shows live sampling of the fill bit.
- Start SHL amt=6, assert reset asynchronously mid-shift (between edges) -> A_par=0, out_bit=0, busy=0, cmd_ready=1 immediately; no done pulse. After release, LOAD 0x11 works normally.

Source files
------------

// File: rtl/param_shift_rotate_reg.sv
// Parametrised shift/rotate register with a valid/ready command port.
// Multi-bit shifts and rotates advance one bit per clock; done pulses on completion.
module param_shift_rotate_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  output logic [WIDTH-1:0] A_par,
  output logic             out_bit,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] a_d;
  logic             bit_d;
  logic             done_d;
  logic [2:0]       step_op;
  logic [WIDTH:0]   step_res;

  // One single-bit step; result is {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       o,
                                                input logic [WIDTH-1:0] a,
                                                input logic             msb,
                                                input logic             lsb);
    logic [WIDTH:0] r;
    r = {1'b0, a};
    case (o)
      OP_SHL:  r = {a[WIDTH-1], a[WIDTH-2:0], lsb};
      OP_SHR:  r = {a[0], msb, a[WIDTH-1:1]};
      OP_ROTL: r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROTR: r = {a[0], a[0], a[WIDTH-1:1]};
      OP_ASR:  r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // A single shifter serves both the accepting edge and the SHIFT steps.
  assign step_op   = (state_q == SHIFT) ? op_q : op;
  assign step_res  = shift_step(step_op, A_par, MSB_in, LSB_in);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    a_d     = A_par;
    bit_d   = out_bit;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_HOLD:  done_d = 1'b1;
            OP_LOAD: begin
              a_d    = I_par;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              a_d    = '0;
              done_d = 1'b1;
            end
            default: begin
              // amt=0 leaves the register and out_bit untouched but still completes
              if (amt != '0) {bit_d, a_d} = step_res;
              if (amt > CNT_W'(1)) begin
                state_d = SHIFT;
                rem_d   = amt - CNT_W'(1);
                op_d    = op;
              end else begin
                done_d = 1'b1;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        {bit_d, a_d} = step_res;
        rem_d        = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      A_par   <= '0;
      out_bit <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      A_par   <= a_d;
      out_bit <= bit_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_param_shift_rotate_reg.sv
// Self-checking bench for param_shift_rotate_reg (WIDTH=8) with a per-step
// arithmetic reference model and randomized commands.
module tb_param_shift_rotate_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SHL  = 3'd2;
  localparam logic [2:0] SHR  = 3'd3;
  localparam logic [2:0] ROTL = 3'd4;
  localparam logic [2:0] ROTR = 3'd5;
  localparam logic [2:0] ASR  = 3'd6;
  localparam logic [2:0] CLR  = 3'd7;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] I_par;
  logic             MSB_in;
  logic             LSB_in;
  logic [WIDTH-1:0] A_par;
  logic             out_bit;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_a;
  logic       m_b;

  always #5 clk = ~clk;

  param_shift_rotate_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op(op), .amt(amt), .I_par(I_par), .MSB_in(MSB_in), .LSB_in(LSB_in),
    .A_par(A_par), .out_bit(out_bit), .busy(busy), .done(done)
  );

  // Reference step using plain integer arithmetic: returns {out bit, value}.
  function automatic logic [8:0] mstep(input logic [2:0] o, input logic [7:0] a, input logic f);
    int v, ob, nv;
    v  = int'(a);
    ob = 0;
    nv = v;
    case (o)
      SHL:  begin ob = v / 128; nv = (v * 2 + int'(f)) % 256; end
      SHR:  begin ob = v % 2;   nv = v / 2 + int'(f) * 128; end
      ROTL: begin ob = v / 128; nv = (v * 2 + v / 128) % 256; end
      ROTR: begin ob = v % 2;   nv = v / 2 + (v % 2) * 128; end
      ASR:  begin ob = v % 2;   nv = v / 2 + (v / 128) * 128; end
      default: ;
    endcase
    return {ob[0], nv[7:0]};
  endfunction

  // Issue one command from IDLE and check every edge until it completes.
  task automatic run_cmd(input string nm, input logic [2:0] o, input logic [CNT_W-1:0] n,
                         input logic [7:0] d, input logic [31:0] pat);
    int edges;
    logic [8:0] r;
    logic exp_busy;
    edges = ((o inside {SHL, SHR, ROTL, ROTR, ASR}) && n > 1) ? int'(n) : 1;
    cmd_valid = 1'b1; op = o; amt = n; I_par = d;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_at_issue: got %b want 1", nm, cmd_ready);
    end
    for (int i = 0; i < edges; i++) begin
      MSB_in = pat[i];
      LSB_in = pat[i];
      if (o == LOAD) m_a = d;
      else if (o == CLR) m_a = 8'h00;
      else if (o != HOLD && n != 0) begin
        r = mstep(o, m_a, pat[i]);
        m_a = r[7:0];
        m_b = r[8];
      end
      @(posedge clk); #1;
      if (i == 0) begin
        cmd_valid = 1'b0; op = 3'($urandom); amt = CNT_W'($urandom); I_par = 8'($urandom);
      end
      exp_busy = (i < edges - 1);
      n_tests++;
      if (A_par !== m_a) begin
        n_fail++; $display("FAIL %s A_par step %0d: got %h want %h", nm, i, A_par, m_a);
      end
      n_tests++;
      if (out_bit !== m_b) begin
        n_fail++; $display("FAIL %s out_bit step %0d: got %b want %b", nm, i, out_bit, m_b);
      end
      n_tests++;
      if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
        n_fail++; $display("FAIL %s busy/ready step %0d: got %b/%b want %b/%b",
                           nm, i, busy, cmd_ready, exp_busy, !exp_busy);
      end
      n_tests++;
      if (done !== (i == edges - 1)) begin
        n_fail++; $display("FAIL %s done step %0d: got %b want %b", nm, i, done, (i == edges - 1));
      end
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; op = LOAD; amt = '0; I_par = 8'hFF; MSB_in = 1'b0; LSB_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk8("reset A_par", A_par, 8'h00);
    chk8("reset flags", {3'b0, out_bit, busy, done, cmd_ready}, 8'b0000_0001);
    #2 reset = 1'b0; cmd_valid = 1'b0;
    m_a = 8'h00; m_b = 1'b0;
    @(posedge clk); #1;
    chk8("post_reset no accept", A_par, 8'h00);
    chk8("post_reset done", {7'b0, done}, 8'h00);
  endtask

  task automatic test_load_clear();
    run_cmd("load", LOAD, 4'd3, 8'hA5, 32'h0);
    chk8("load value", A_par, 8'hA5);
    @(posedge clk); #1;
    chk8("load done once", {6'b0, done, busy}, 8'h00);
    run_cmd("clear", CLR, 4'd0, 8'h77, 32'h0);
    chk8("clear value", A_par, 8'h00);
  endtask

  task automatic test_shl();
    run_cmd("load_a5", LOAD, 4'd0, 8'hA5, 32'h0);
    run_cmd("shl3", SHL, 4'd3, 8'h00, 32'hFFFF_FFFF);
    chk8("shl3 final", A_par, 8'h2F);
    chk8("shl3 out_bit", {7'b0, out_bit}, 8'h01);
  endtask

  task automatic test_rotr_asr();
    run_cmd("load_81", LOAD, 4'd0, 8'h81, 32'h0);
    run_cmd("rotr12", ROTR, 4'd12, 8'h00, $urandom);
    chk8("rotr12 final", A_par, 8'h18);
    chk8("rotr12 out_bit", {7'b0, out_bit}, 8'h00);
    run_cmd("load_90", LOAD, 4'd0, 8'h90, 32'h0);
    run_cmd("asr2", ASR, 4'd2, 8'h00, 32'hFFFF_FFFF);
    chk8("asr2 final", A_par, 8'hE4);
  endtask

  task automatic test_noop_hold();
    run_cmd("load_3c", LOAD, 4'd0, 8'h3C, 32'h0);
    run_cmd("shl0", SHL, 4'd0, 8'h00, 32'hFFFF_FFFF);
    chk8("shl0 unchanged", A_par, 8'h3C);
    run_cmd("hold", HOLD, 4'd7, 8'hFF, 32'h0);
    chk8("hold unchanged", A_par, 8'h3C);
  endtask

  task automatic test_shr_live();
    run_cmd("load_ff", LOAD, 4'd0, 8'hFF, 32'h0);
    run_cmd("shr5", SHR, 4'd5, 8'h00, 32'h0000_0015);
    chk8("shr5 live fill", A_par, 8'hAF);
  endtask

  task automatic test_back_to_back();
    run_cmd("load_81b", LOAD, 4'd0, 8'h81, 32'h0);
    cmd_valid = 1'b1; op = ROTL; amt = 4'd4; I_par = 8'h00; MSB_in = 1'b0; LSB_in = 1'b0;
    @(posedge clk); #1;
    op = LOAD; I_par = 8'h5A; amt = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk8("b2b busy", {7'b0, busy}, (k < 2) ? 8'h01 : 8'h00);
    end
    chk8("b2b rotl result", A_par, 8'h18);
    chk8("b2b rotl done/ready", {6'b0, done, cmd_ready}, 8'h03);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk8("b2b queued load", A_par, 8'h5A);
    chk8("b2b load done/out", {6'b0, done, out_bit}, 8'h02);
    m_a = 8'h5A; m_b = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    run_cmd("load_c3", LOAD, 4'd0, 8'hC3, 32'h0);
    cmd_valid = 1'b1; op = SHL; amt = 4'd6; LSB_in = 1'b1; MSB_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk8("midrst A_par", A_par, 8'h00);
    chk8("midrst flags", {3'b0, out_bit, busy, done, cmd_ready}, 8'b0000_0001);
    cmd_valid = 1'b1; op = LOAD; I_par = 8'hEE;
    @(posedge clk); #1;
    chk8("midrst held A_par", A_par, 8'h00);
    #2 reset = 1'b0; cmd_valid = 1'b0;
    m_a = 8'h00; m_b = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL midrst no_done: got %0d active cycles want 0", seen_done);
    end
    run_cmd("load_11", LOAD, 4'd0, 8'h11, 32'h0);
    chk8("post_midrst load", A_par, 8'h11);
  endtask

  task automatic test_random();
    logic [2:0] o;
    for (int k = 0; k < 30; k++) begin
      o = 3'($urandom);
      run_cmd("random", o, CNT_W'($urandom_range(0, 15)), 8'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk8("random idle done", {7'b0, done}, 8'h00);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_clear();
    test_shl();
    test_rotr_asr();
    test_noop_hold();
    test_shr_live();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
